// File: rtl/log2_burst_arbiter.sv
// log2_burst_arbiter: round-robin sharing of one log2 burst engine.
// Optional response watchdog enabled by defining LOG2_ARB_TIMEOUT_EN.
module log2_burst_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int MAX_BURST      = 6,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic [NUM_REQ-1:0]   rsp_valid,
    output logic [7:0]           rsp_data,
    output logic                 rsp_last,
    output logic [7:0]           eng_x,
    output logic                 eng_validx,
    input  logic [7:0]           eng_y,
    input  logic                 eng_validy,
    output logic                 busy,
    output logic [2:0]           grant_id,
    output logic                 stray
);

    typedef enum logic [1:0] {IDLE, SEND, GAP, WAIT_RSP} state_t;

    state_t             state;
    logic [2:0]         rr_ptr;
    logic [2:0]         sent_cnt;
    logic [2:0]         rsp_cnt;
    logic [2:0]         pick;
    logic [2:0]         hi_pick;
    logic [2:0]         lo_pick;
    logic               hi_found;
    logic [2:0]         rr_next;
    logic [NUM_REQ-1:0] pick_oh;
    logic [NUM_REQ-1:0] grant_oh;
    logic               cur_valid;
    logic               cur_last;
    logic [7:0]         cur_data;
    logic               burst_end;
    logic               last_beat;
`ifdef LOG2_ARB_TIMEOUT_EN
    logic [7:0]         wd_cnt;
`endif

    // Round-robin search: lowest valid index at or after rr_ptr, else lowest valid.
    always_comb begin
        hi_pick  = 3'd0;
        lo_pick  = 3'd0;
        hi_found = 1'b0;
        pick_oh  = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                lo_pick = 3'(i);
                if (3'(i) >= rr_ptr) begin
                    hi_pick  = 3'(i);
                    hi_found = 1'b1;
                end
            end
        end
        pick = hi_found ? hi_pick : lo_pick;
        for (int i = 0; i < NUM_REQ; i++) begin
            pick_oh[i] = (pick == 3'(i));
        end
    end

    // Select the granted requester's lines.
    always_comb begin
        grant_oh  = '0;
        cur_valid = 1'b0;
        cur_last  = 1'b0;
        cur_data  = 8'd0;
        for (int i = 0; i < NUM_REQ; i++) begin
            grant_oh[i] = (grant_id == 3'(i));
            if (grant_oh[i]) begin
                cur_valid = req_valid[i];
                cur_last  = req_last[i];
                cur_data  = req_data[8*i +: 8];
            end
        end
    end

    assign rr_next   = (grant_id == 3'(NUM_REQ - 1)) ? 3'd0 : grant_id + 3'd1;
    assign burst_end = !cur_valid || cur_last ||
                       (sent_cnt + 3'd1 == 3'(MAX_BURST));
    assign last_beat = (rsp_cnt + 3'd1 == sent_cnt);

    // Grant, forward the burst, then route the engine's results back.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            rr_ptr     <= 3'd0;
            sent_cnt   <= 3'd0;
            rsp_cnt    <= 3'd0;
            req_ready  <= '0;
            rsp_valid  <= '0;
            rsp_data   <= 8'd0;
            rsp_last   <= 1'b0;
            eng_x      <= 8'd0;
            eng_validx <= 1'b0;
            busy       <= 1'b0;
            grant_id   <= 3'd0;
            stray      <= 1'b0;
`ifdef LOG2_ARB_TIMEOUT_EN
            wd_cnt     <= 8'd0;
`endif
        end else begin
            rsp_valid  <= '0;
            rsp_last   <= 1'b0;
            eng_validx <= 1'b0;
            if (eng_validy && state != WAIT_RSP) begin
                stray <= 1'b1;
            end
            unique case (state)
                IDLE: begin
                    if (|req_valid) begin
                        grant_id  <= pick;
                        req_ready <= pick_oh;
                        sent_cnt  <= 3'd0;
                        rsp_cnt   <= 3'd0;
                        busy      <= 1'b1;
                        state     <= SEND;
                    end
                end
                SEND: begin
                    if (cur_valid) begin
                        eng_x      <= cur_data;
                        eng_validx <= 1'b1;
                        sent_cnt   <= sent_cnt + 3'd1;
                    end
                    if (burst_end) begin
                        req_ready <= '0;
                        state     <= GAP;
                    end
                end
                GAP: begin
`ifdef LOG2_ARB_TIMEOUT_EN
                    wd_cnt <= 8'd0;
`endif
                    if (sent_cnt == 3'd0) begin
                        busy   <= 1'b0;
                        rr_ptr <= rr_next;
                        state  <= IDLE;
                    end else begin
                        state <= WAIT_RSP;
                    end
                end
                WAIT_RSP: begin
                    if (eng_validy && last_beat) begin
                        rsp_valid <= grant_oh;
                        rsp_data  <= eng_y;
                        rsp_last  <= 1'b1;
                        rsp_cnt   <= rsp_cnt + 3'd1;
                        busy      <= 1'b0;
                        rr_ptr    <= rr_next;
                        state     <= IDLE;
                    end
`ifdef LOG2_ARB_TIMEOUT_EN
                    else if (wd_cnt == 8'(TIMEOUT_CYCLES - 1)) begin
                        rsp_valid <= grant_oh;
                        rsp_data  <= 8'hFF;
                        rsp_last  <= 1'b1;
                        busy      <= 1'b0;
                        rr_ptr    <= rr_next;
                        state     <= IDLE;
                    end
`endif
                    else begin
`ifdef LOG2_ARB_TIMEOUT_EN
                        wd_cnt <= wd_cnt + 8'd1;
`endif
                        if (eng_validy) begin
                            rsp_valid <= grant_oh;
                            rsp_data  <= eng_y;
                            rsp_cnt   <= rsp_cnt + 3'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_log2_burst_arbiter.sv
// tb_log2_burst_arbiter: requesters, engine model and reference scoreboard.
// Directed cases pin the model; randomized bursts exercise the rest.
module tb_log2_burst_arbiter;

    localparam int N  = 4;
    localparam int MB = 6;
    localparam int TO = 64;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [8*N-1:0] req_data;
    logic [N-1:0]   req_last;
    logic [N-1:0]   req_ready;
    logic [N-1:0]   rsp_valid;
    logic [7:0]     rsp_data;
    logic           rsp_last;
    logic [7:0]     eng_x;
    logic           eng_validx;
    logic [7:0]     eng_y;
    logic           eng_validy;
    logic           busy;
    logic [2:0]     grant_id;
    logic           stray;

    always #5 clk = ~clk;

    log2_burst_arbiter #(.NUM_REQ(N), .MAX_BURST(MB), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
        .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_last(rsp_last),
        .eng_x(eng_x), .eng_validx(eng_validx),
        .eng_y(eng_y), .eng_validy(eng_validy),
        .busy(busy), .grant_id(grant_id), .stray(stray)
    );

    typedef struct packed {
        logic [7:0] d;
        logic       l;
        logic [1:0] gap;
    } item_t;

    typedef struct {
        logic [N-1:0] id;
        logic [7:0]   d;
        logic         l;
    } beat_t;

    int    checks = 0;
    int    errors = 0;
    item_t rq[N][$];
    int    lowcnt[N];
    beat_t log_q[$];
    logic [7:0] ebuf[$];
    logic [7:0] eout[$];
    bit    silent = 0;
    bit    inject = 0;

    // scoreboard model state
    int         phase;
    int         mg;
    int         rr;
    int         cnt;
    int         rptr;
    int         wd;
    logic [7:0] sent_q[$];
    logic [N-1:0] exp_ready;
    logic [N-1:0] exp_rv;
    logic       exp_vx;
    logic [7:0] exp_x;
    logic [7:0] exp_rd;
    logic       exp_rl;
    logic       exp_stray;
    logic [2:0] exp_gid;

    function automatic logic [7:0] clog2b(input logic [7:0] x);
        int k = 0;
        while ((1 << k) < int'(x)) k++;
        return 8'(k);
    endfunction

    function automatic int pick_rr(input logic [N-1:0] v, input int p);
        for (int k = 0; k < N; k++) begin
            if (v[(p + k) % N]) return (p + k) % N;
        end
        return 0;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic reset_model();
        phase = 0; rr = 0; mg = 0; cnt = 0; rptr = 0; wd = 0;
        sent_q.delete();
        exp_ready = '0; exp_rv = '0; exp_vx = 0; exp_x = 0;
        exp_rd = 0; exp_rl = 0; exp_stray = 0; exp_gid = 0;
    endtask

    // Requester drivers: present queued bytes, advance on acceptance.
    initial begin
        logic [N-1:0] acc;
        item_t it;
        req_valid = '0; req_data = '0; req_last = '0;
        for (int i = 0; i < N; i++) lowcnt[i] = 0;
        forever begin
            @(negedge clk);
            acc = req_valid & req_ready;
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) begin
                if (acc[i] && rq[i].size() > 0) begin
                    it = rq[i].pop_front();
                    lowcnt[i] = int'(it.gap);
                end
                if (lowcnt[i] > 0) begin
                    req_valid[i] = 1'b0;
                    lowcnt[i]--;
                end else if (rq[i].size() > 0) begin
                    req_valid[i] = 1'b1;
                    req_data[8*i +: 8] = rq[i][0].d;
                    req_last[i] = rq[i][0].l;
                end else begin
                    req_valid[i] = 1'b0;
                    req_last[i] = 1'b0;
                end
            end
        end
    end

    // Engine model: buffers a validx burst, answers ceil(log2) after it ends.
    initial begin
        logic vx;
        logic [7:0] x;
        logic r;
        int edelay;
        eng_validy = 0; eng_y = 0; edelay = 0;
        forever begin
            @(negedge clk);
            vx = eng_validx; x = eng_x; r = rst;
            @(posedge clk);
            #1;
            eng_validy = 0;
            if (r || rst) begin
                ebuf.delete(); eout.delete(); edelay = 0;
                continue;
            end
            if (vx) ebuf.push_back(x);
            else if (ebuf.size() > 0) begin
                while (ebuf.size() > 0) eout.push_back(ebuf.pop_front());
                edelay = $urandom_range(0, 2);
            end
            if (inject) begin
                eng_validy = 1; eng_y = 8'hAA; inject = 0;
            end else if (eout.size() > 0 && !silent) begin
                if (edelay > 0) edelay--;
                else if ($urandom_range(0, 3) != 0) begin
                    eng_validy = 1;
                    eng_y = clog2b(eout.pop_front());
                end
            end
        end
    end

    // Compare process: check every cycle, then advance the model.
    initial begin
        logic [7:0] b;
        beat_t bt;
        reset_model();
        forever begin
            @(negedge clk);
            if (rst) begin
                chk("rst_ready", 32'(req_ready), 0);
                chk("rst_rsp_valid", 32'(rsp_valid), 0);
                chk("rst_rsp_data", 32'(rsp_data), 0);
                chk("rst_eng", {23'd0, eng_validx, eng_x}, 0);
                chk("rst_misc", {27'd0, busy, grant_id, stray}, 0);
                reset_model();
                continue;
            end
            chk("ready", 32'(req_ready), 32'(exp_ready));
            chk("eng_validx", 32'(eng_validx), 32'(exp_vx));
            if (exp_vx) chk("eng_x", 32'(eng_x), 32'(exp_x));
            chk("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
            chk("rsp_last", 32'(rsp_last), 32'(exp_rl));
            if (exp_rv != 0) chk("rsp_data", 32'(rsp_data), 32'(exp_rd));
            chk("busy", 32'(busy), 32'(phase != 0));
            chk("grant_id", 32'(grant_id), 32'(exp_gid));
            chk("stray", 32'(stray), 32'(exp_stray));
            if (rsp_valid != 0) begin
                bt.id = rsp_valid; bt.d = rsp_data; bt.l = rsp_last;
                log_q.push_back(bt);
            end
            exp_vx = 0; exp_rv = '0; exp_rl = 0;
            if (eng_validy && phase != 3) exp_stray = 1;
            case (phase)
                0: if (req_valid != 0) begin
                    mg = pick_rr(req_valid, rr);
                    exp_gid = 3'(mg);
                    exp_ready = '0;
                    exp_ready[mg] = 1'b1;
                    cnt = 0;
                    sent_q.delete();
                    phase = 1;
                end
                1: begin
                    if (req_valid[mg]) begin
                        b = req_data[8*mg +: 8];
                        sent_q.push_back(b);
                        exp_vx = 1; exp_x = b;
                        cnt++;
                    end
                    if (!req_valid[mg] || req_last[mg] || cnt == MB) begin
                        exp_ready = '0;
                        phase = 2;
                    end
                end
                2: begin
                    rptr = 0; wd = 0;
                    if (cnt == 0) begin
                        phase = 0; rr = (mg + 1) % N;
                    end else phase = 3;
                end
                default: begin
                    if (eng_validy && rptr == cnt - 1) begin
                        exp_rv[mg] = 1'b1;
                        exp_rd = clog2b(sent_q[rptr]);
                        exp_rl = 1;
                        phase = 0; rr = (mg + 1) % N;
                    end
`ifdef LOG2_ARB_TIMEOUT_EN
                    else if (wd == TO - 1) begin
                        exp_rv[mg] = 1'b1;
                        exp_rd = 8'hFF;
                        exp_rl = 1;
                        phase = 0; rr = (mg + 1) % N;
                    end
`endif
                    else begin
                        wd++;
                        if (eng_validy) begin
                            exp_rv[mg] = 1'b1;
                            exp_rd = clog2b(sent_q[rptr]);
                            rptr++;
                        end
                    end
                end
            endcase
        end
    end

    task automatic wait_idle(input int limit);
        int n = 0;
        int quiet = 0;
        bit empty;
        while (quiet < 4 && n < limit) begin
            @(negedge clk);
            #1;
            n++;
            empty = (eout.size() == 0) && (ebuf.size() == 0) && !inject;
            for (int i = 0; i < N; i++) begin
                if (rq[i].size() > 0 || lowcnt[i] > 0) empty = 0;
            end
            if (empty && phase == 0 && req_valid == 0) quiet++;
            else quiet = 0;
        end
        checks++;
        if (quiet < 4) begin
            errors++;
            $display("FAIL idle_wait actual=busy required=idle within %0d cycles", limit);
        end
    endtask

    task automatic push(input int r, input logic [7:0] d, input logic l);
        item_t it;
        it.d = d; it.l = l; it.gap = 2'd0;
        rq[r].push_back(it);
    endtask

    initial begin
        logic [N-1:0] ord[4];
        logic [7:0]   t1d[3];
        int k;
        int n;
        item_t it;
        ord = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
        t1d = '{8'd3, 8'd0, 8'd8};
        rst = 1;
        repeat (3) @(posedge clk);
        #1 rst = 0;

        // all four requesters valid together
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            push(i, 8'(8'h10 + i), 1'b0);
            push(i, 8'(8'h40 + i), 1'b1);
        end
        wait_idle(400);
        k = 0;
        foreach (log_q[j]) begin
            if (log_q[j].l && k < 4) begin
                chk("t2_order", 32'(log_q[j].id), 32'(ord[k]));
                k++;
            end
        end
        chk("t2_bursts", k, 4);

        // req0 sends 8,1,255
        log_q.delete();
        @(negedge clk);
        push(0, 8'd8, 1'b0); push(0, 8'd1, 1'b0); push(0, 8'd255, 1'b1);
        wait_idle(400);
        chk("t1_beats", log_q.size(), 3);
        if (log_q.size() == 3) begin
            for (int j = 0; j < 3; j++) begin
                chk("t1_data", 32'(log_q[j].d), 32'(t1d[j]));
                chk("t1_last", 32'(log_q[j].l), 32'(j == 2));
                chk("t1_id", 32'(log_q[j].id), 1);
            end
        end

        // rr_ptr now 1: req1 wins over req0
        log_q.delete();
        @(negedge clk);
        push(0, 8'd5, 1'b1); push(1, 8'd6, 1'b1);
        wait_idle(400);
        chk("rr_first", log_q.size() > 0 ? 32'(log_q[0].id) : 0, 2);

        // req2 streams 9 bytes without last
        log_q.delete();
        @(negedge clk);
        for (int j = 0; j < 9; j++) push(2, 8'(j * 28 + 3), 1'b0);
        wait_idle(600);
        chk("t3_beats", log_q.size(), 9);
        if (log_q.size() == 9) begin
            chk("t3_last_6th", 32'(log_q[5].l), 1);
            chk("t3_last_9th", 32'(log_q[8].l), 1);
            chk("t3_mid", 32'(log_q[4].l), 0);
            chk("t3_id", 32'(log_q[7].id), 4);
        end

        // req1 drops valid after 2 bytes, then a stray result
        log_q.delete();
        @(negedge clk);
        push(1, 8'd100, 1'b0); push(1, 8'd3, 1'b0);
        wait_idle(400);
        chk("t4_beats", log_q.size(), 2);
        if (log_q.size() == 2) begin
            chk("t4_last", 32'(log_q[1].l), 1);
            chk("t4_first", 32'(log_q[0].l), 0);
            chk("t4_data", 32'(log_q[1].d), 2);
        end
        inject = 1;
        repeat (4) @(negedge clk);
        chk("t4_stray", 32'(stray), 1);

        // reset in the middle of a burst
        @(negedge clk);
        for (int j = 0; j < 5; j++) push(3, 8'(j + 1), 1'b0);
        n = 0;
        while (!req_ready[3] && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("t5_granted", 32'(req_ready), 8);
        @(posedge clk);
        #1 rst = 1;
        rq[3].delete();
        lowcnt[3] = 0;
        @(negedge clk);
        chk("t5_busy", 32'(busy), 0);
        chk("t5_gid", 32'(grant_id), 0);
        chk("t5_stray", 32'(stray), 0);
        chk("t5_validx", 32'(eng_validx), 0);
        @(posedge clk);
        #1 rst = 0;
        log_q.delete();
        @(negedge clk);
        push(0, 8'h20, 1'b0); push(0, 8'h21, 1'b1);
        wait_idle(400);
        chk("t5_regrant", log_q.size() == 2 ? 32'(log_q[1].id) : 0, 1);

`ifdef LOG2_ARB_TIMEOUT_EN
        // silent engine: watchdog answers 8'hFF
        log_q.delete();
        silent = 1;
        @(negedge clk);
        push(1, 8'd9, 1'b0); push(1, 8'd17, 1'b1);
        n = 0;
        while (!(log_q.size() > 0 && log_q[log_q.size()-1].l) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("t6_seen", 32'(n < 200), 1);
        if (log_q.size() > 0) begin
            chk("t6_data", 32'(log_q[log_q.size()-1].d), 32'hFF);
            chk("t6_id", 32'(log_q[log_q.size()-1].id), 2);
        end
        eout.delete();
        silent = 0;
        wait_idle(100);
        chk("t6_idle", 32'(busy), 0);
`endif

        // randomized bursts on all requesters
        @(negedge clk);
        for (int b = 0; b < 8; b++) begin
            for (int i = 0; i < N; i++) begin
                int  len;
                bit  drop;
                len  = $urandom_range(1, 9);
                drop = ($urandom_range(0, 3) == 0);
                for (int j = 0; j < len; j++) begin
                    it.d = 8'($urandom);
                    it.l = !drop && (j == len - 1);
                    it.gap = 2'd0;
                    if (j == len - 1) begin
                        it.gap = drop ? 2'($urandom_range(1, 3))
                                      : 2'($urandom_range(0, 2));
                    end
                    rq[i].push_back(it);
                end
            end
        end
        wait_idle(20000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #800000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
